// File: rtl/wasm_value_stack.sv
// WebAssembly operand stack: DEPTH x WIDTH slots with push/drop/unop/binop/dup/select.
// Any illegal op latches a sticky trap code and blocks further ops until reset.
module wasm_value_stack #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 16,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             op_valid,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] push_data,
   output logic             op_ready,
   output logic [WIDTH-1:0] top0,
   output logic [WIDTH-1:0] top1,
   output logic [WIDTH-1:0] top2,
   output logic [CW-1:0]    count,
   output logic [WIDTH-1:0] result,
   output logic             result_empty,
   output logic [3:0]       trap
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [2:0] OP_NOP    = 3'd0;
   localparam logic [2:0] OP_PUSH   = 3'd1;
   localparam logic [2:0] OP_DROP   = 3'd2;
   localparam logic [2:0] OP_UNOP   = 3'd3;
   localparam logic [2:0] OP_BINOP  = 3'd4;
   localparam logic [2:0] OP_DUP    = 3'd5;
   localparam logic [2:0] OP_SELECT = 3'd6;
   localparam logic [2:0] OP_RSVD   = 3'd7;

   localparam logic [3:0] TRAP_NONE  = 4'd0;
   localparam logic [3:0] TRAP_OVF   = 4'd1;
   localparam logic [3:0] TRAP_UNF   = 4'd2;
   localparam logic [3:0] TRAP_ILLEG = 4'd3;

   localparam logic [CW-1:0] C1    = CW'(1);
   localparam logic [CW-1:0] C2    = CW'(2);
   localparam logic [CW-1:0] C3    = CW'(3);
   localparam logic [CW-1:0] CFULL = CW'(DEPTH);

   typedef enum logic {
      RUN,
      TRAPPED
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       trap_q, trap_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] mem [DEPTH];

   logic             wr_en;
   logic [AW-1:0]    wr_idx;
   logic [WIDTH-1:0] wr_data;
   logic [3:0]       fault;

   logic             has1, has2, has3, full;

   assign has1 = cnt_q >= C1;
   assign has2 = cnt_q >= C2;
   assign has3 = cnt_q >= C3;
   assign full = cnt_q == CFULL;

   assign top0 = has1 ? mem[AW'(cnt_q - C1)] : '0;
   assign top1 = has2 ? mem[AW'(cnt_q - C2)] : '0;
   assign top2 = has3 ? mem[AW'(cnt_q - C3)] : '0;

   assign count        = cnt_q;
   assign result       = top0;
   assign result_empty = cnt_q == '0;
   assign trap         = trap_q;
   assign op_ready     = state_q == RUN;

   always_comb begin
      state_d = state_q;
      trap_d  = trap_q;
      cnt_d   = cnt_q;
      wr_en   = 1'b0;
      wr_idx  = '0;
      wr_data = push_data;
      fault   = TRAP_NONE;

      if (state_q == RUN && op_valid) begin
         unique case (op)
            OP_NOP: begin
            end
            OP_PUSH: begin
               if (full) begin
                  fault = TRAP_OVF;
               end else begin
                  wr_en  = 1'b1;
                  wr_idx = AW'(cnt_q);
                  cnt_d  = cnt_q + C1;
               end
            end
            OP_DROP: begin
               if (!has1) fault = TRAP_UNF;
               else cnt_d = cnt_q - C1;
            end
            OP_UNOP: begin
               if (!has1) begin
                  fault = TRAP_UNF;
               end else begin
                  wr_en  = 1'b1;
                  wr_idx = AW'(cnt_q - C1);
               end
            end
            OP_BINOP: begin
               if (!has2) begin
                  fault = TRAP_UNF;
               end else begin
                  wr_en  = 1'b1;
                  wr_idx = AW'(cnt_q - C2);
                  cnt_d  = cnt_q - C1;
               end
            end
            OP_DUP: begin
               // full wins: with DEPTH>=3 an empty stack is never full
               if (full) begin
                  fault = TRAP_OVF;
               end else if (!has1) begin
                  fault = TRAP_UNF;
               end else begin
                  wr_en   = 1'b1;
                  wr_idx  = AW'(cnt_q);
                  wr_data = top0;
                  cnt_d   = cnt_q + C1;
               end
            end
            OP_SELECT: begin
               if (!has3) begin
                  fault = TRAP_UNF;
               end else begin
                  wr_en   = 1'b1;
                  wr_idx  = AW'(cnt_q - C3);
                  wr_data = (top0 != '0) ? top2 : top1;
                  cnt_d   = cnt_q - C2;
               end
            end
            OP_RSVD: begin
               fault = TRAP_ILLEG;
            end
         endcase

         if (fault != TRAP_NONE) begin
            wr_en   = 1'b0;
            cnt_d   = cnt_q;
            trap_d  = fault;
            state_d = TRAPPED;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
         trap_q  <= TRAP_NONE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         trap_q  <= trap_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

endmodule

// File: tb/tb_wasm_value_stack.sv
// Scoreboard bench for wasm_value_stack: a reference stack model
// queues expected state per op, compared one cycle later.
module tb_wasm_value_stack;

   localparam int W  = 64;
   localparam int D  = 16;
   localparam int CW = $clog2(D + 1);

   logic          clk = 1'b0;
   logic          reset;
   logic          op_valid;
   logic [2:0]    op;
   logic [W-1:0]  push_data;
   logic          op_ready;
   logic [W-1:0]  top0, top1, top2, result;
   logic [CW-1:0] count;
   logic          result_empty;
   logic [3:0]    trap;

   wasm_value_stack #(.WIDTH(W), .DEPTH(D)) dut (
      .clk          (clk),
      .reset        (reset),
      .op_valid     (op_valid),
      .op           (op),
      .push_data    (push_data),
      .op_ready     (op_ready),
      .top0         (top0),
      .top1         (top1),
      .top2         (top2),
      .count        (count),
      .result       (result),
      .result_empty (result_empty),
      .trap         (trap)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [CW-1:0] cnt;
      logic [W-1:0]  t0;
      logic [W-1:0]  t1;
      logic [W-1:0]  t2;
      logic [3:0]    trp;
      logic          rdy;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   logic [W-1:0] ms [D];
   int           mc;
   logic [3:0]   mt;
   logic         mr;

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] mtop(int k);
      return (mc > k) ? ms[mc-1-k] : '0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < D; i++) ms[i] = '0;
      mc = 0;
      mt = 4'd0;
      mr = 1'b1;
   endtask

   task automatic model_fault(logic [3:0] code);
      mt = code;
      mr = 1'b0;
   endtask

   task automatic model_op(logic v, logic [2:0] o, logic [W-1:0] d);
      logic [W-1:0] sel;
      if (!v || !mr) return;
      case (o)
         3'd1: if (mc == D) model_fault(4'd1);
               else begin ms[mc] = d; mc++; end
         3'd2: if (mc < 1) model_fault(4'd2);
               else mc--;
         3'd3: if (mc < 1) model_fault(4'd2);
               else ms[mc-1] = d;
         3'd4: if (mc < 2) model_fault(4'd2);
               else begin ms[mc-2] = d; mc--; end
         3'd5: if (mc == D) model_fault(4'd1);
               else if (mc < 1) model_fault(4'd2);
               else begin ms[mc] = ms[mc-1]; mc++; end
         3'd6: if (mc < 3) model_fault(4'd2);
               else begin
                  sel = (ms[mc-1] != '0) ? ms[mc-3] : ms[mc-2];
                  ms[mc-3] = sel;
                  mc -= 2;
               end
         3'd7: model_fault(4'd3);
         default: ;
      endcase
   endtask

   task automatic compare_out();
      exp_t e;
      if (sb.size() == 0) begin
         check("sb_empty", 64'd1, 64'd0);
         return;
      end
      e = sb.pop_front();
      check("count", 64'(count), 64'(e.cnt));
      check("top0", top0, e.t0);
      check("top1", top1, e.t1);
      check("top2", top2, e.t2);
      check("result", result, e.t0);
      check("empty", 64'(result_empty), 64'(e.cnt == '0));
      check("trap", 64'(trap), 64'(e.trp));
      check("ready", 64'(op_ready), 64'(e.rdy));
   endtask

   task automatic do_op(logic v, logic [2:0] o, logic [W-1:0] d);
      op_valid  = v;
      op        = o;
      push_data = d;
      model_op(v, o, d);
      sb.push_back({CW'(mc), mtop(0), mtop(1), mtop(2), mt, mr});
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      compare_out();
   endtask

   task automatic check_idle(string tag);
      check({tag, "_cnt"}, 64'(count), 64'd0);
      check({tag, "_res"}, result, 64'd0);
      check({tag, "_emp"}, 64'(result_empty), 64'd1);
      check({tag, "_trap"}, 64'(trap), 64'd0);
      check({tag, "_rdy"}, 64'(op_ready), 64'd1);
   endtask

   // asynchronous pulse in the middle of a cycle, checked before the next edge
   task automatic pulse_reset();
      @(posedge clk);
      #3 reset = 1'b0;
      model_reset();
      #1 check_idle("arst");
      reset = 1'b1;
   endtask

   initial begin
      reset     = 1'b0;
      op_valid  = 1'b0;
      op        = 3'd0;
      push_data = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      repeat (8) @(posedge clk);
      #1 check_idle("rst");

      do_op(1'b1, 3'd1, 64'h5);
      do_op(1'b1, 3'd3, 64'h0);
      do_op(1'b1, 3'd0, 64'hdead);
      do_op(1'b1, 3'd2, 64'h0);

      for (int c = 0; c < 2; c++) begin
         do_op(1'b1, 3'd1, 64'd10);
         do_op(1'b1, 3'd1, 64'd20);
         do_op(1'b1, 3'd1, (c == 0) ? 64'd0 : 64'd7);
         do_op(1'b1, 3'd6, 64'h0);
         check("sel_res", result, (c == 0) ? 64'd20 : 64'd10);
         do_op(1'b1, 3'd2, 64'h0);
      end

      do_op(1'b1, 3'd1, 64'h8000_0000_0000_0000);
      do_op(1'b1, 3'd1, 64'h3);
      do_op(1'b1, 3'd1, 64'h1);
      do_op(1'b1, 3'd1, 64'h1_0000_0000);
      do_op(1'b1, 3'd6, 64'h0);
      do_op(1'b1, 3'd5, 64'h0);
      do_op(1'b1, 3'd4, 64'hffff_ffff_ffff_ffff);
      do_op(1'b0, 3'd1, 64'h77);
      pulse_reset();

      for (int i = 0; i < D; i++) do_op(1'b1, 3'd1, 64'(i));
      check("full_cnt", 64'(count), 64'(D));
      do_op(1'b1, 3'd1, 64'h99);
      check("ovf_trap", 64'(trap), 64'd1);
      do_op(1'b1, 3'd1, 64'h98);
      do_op(1'b1, 3'd2, 64'h0);
      pulse_reset();

      do_op(1'b1, 3'd1, 64'h42);
      for (int i = 0; i < D - 1; i++) do_op(1'b1, 3'd5, 64'h0);
      do_op(1'b1, 3'd5, 64'h0);
      pulse_reset();

      do_op(1'b1, 3'd4, 64'h1);
      check("unf_trap", 64'(trap), 64'd2);
      pulse_reset();

      do_op(1'b1, 3'd5, 64'h0);
      pulse_reset();

      do_op(1'b1, 3'd1, 64'h11);
      do_op(1'b1, 3'd1, 64'h22);
      do_op(1'b1, 3'd1, 64'h33);
      do_op(1'b1, 3'd7, 64'h44);
      check("ill_trap", 64'(trap), 64'd3);
      for (int i = 0; i < 6; i++)
         do_op(i[0], 3'(i), 64'(i + 100));
      pulse_reset();
      do_op(1'b1, 3'd1, 64'h5a);

      if (sb.size() != 0) check("sb_left", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
